// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with a two-flop input synchronizer.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx #(
  parameter int NB_DATA      = 8,
  parameter int BAUD_DIVISOR = 163
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data_rx,
  output logic               o_rx_done,
  output logic               o_framing_error,
  output logic               o_parity_error
);

  localparam int TW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIVISOR - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic               r_rx_meta;
  logic               r_rx_sync;
  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_s;
  logic [3:0]         w_s_next;
  logic [NW-1:0]      r_n;
  logic [NW-1:0]      w_n_next;
  logic [NB_DATA-1:0] r_shift;
  logic [NB_DATA-1:0] w_shift_next;
  logic [NB_DATA-1:0] r_data_rx;
  logic [NB_DATA-1:0] w_data_next;
  logic               r_rx_done;
  logic               w_done_next;
  logic               r_frame_err;
  logic               w_frame_next;
`ifdef UART_RX_PARITY_EN
  logic               r_par_bit;
  logic               w_par_bit_next;
  logic               r_par_err;
  logic               w_par_err_next;
`endif

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_tick_cnt <= '0;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_s_next       = r_s;
    w_n_next       = r_n;
    w_shift_next   = r_shift;
    w_data_next    = r_data_rx;
    w_done_next    = 1'b0;
    w_frame_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_next = r_par_bit;
    w_par_err_next = 1'b0;
`endif
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rx_sync) begin
            w_state_next = START;
            w_s_next     = '0;
          end
        end
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        START: begin
          if (r_s == 4'd7) begin
            if (!r_rx_sync) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
        DATA: begin
          if (r_s == 4'd15) begin
            w_shift_next = {r_rx_sync, r_shift[NB_DATA-1:1]};
            w_s_next     = '0;
            w_n_next     = r_n + NW'(1);
            if (r_n == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = PARITY;
`else
              w_state_next = STOP;
`endif
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_s == 4'd15) begin
            w_par_bit_next = r_rx_sync;
            w_s_next       = '0;
            w_state_next   = STOP;
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
`endif
        // Framing error outranks parity error; only a clean frame updates data.
        STOP: begin
          if (r_s == 4'd15) begin
            w_state_next = IDLE;
            w_s_next     = '0;
            if (!r_rx_sync) begin
              w_frame_next = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (^{r_shift, r_par_bit}) begin
              w_par_err_next = 1'b1;
            end
`endif
            else begin
              w_data_next = r_shift;
              w_done_next = 1'b1;
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_shift     <= '0;
      r_data_rx   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_n         <= w_n_next;
      r_shift     <= w_shift_next;
      r_data_rx   <= w_data_next;
      r_rx_done   <= w_done_next;
      r_frame_err <= w_frame_next;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= w_par_bit_next;
      r_par_err   <= w_par_err_next;
`endif
    end
  end

  assign o_data_rx       = r_data_rx;
  assign o_rx_done       = r_rx_done;
  assign o_framing_error = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign o_parity_error  = r_par_err;
`else
  assign o_parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx at BAUD_DIVISOR=2.
// Expected outcomes come from a frame-level model: stop bit, then even parity, then data.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int NB_DATA      = 8;
  localparam int BAUD_DIVISOR = 2;
  localparam int BIT_CLOCKS   = 16 * BAUD_DIVISOR;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_rx    = 1'b1;
  logic [NB_DATA-1:0] o_data_rx;
  logic               o_rx_done;
  logic               o_framing_error;
  logic               o_parity_error;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int startCycle  = 0;
  int lastLatency = 0;
  int doneCount   = 0;
  int ferrCount   = 0;
  int perrCount   = 0;
  int doubleDone  = 0;
  logic prevDone  = 1'b0;
  logic [NB_DATA-1:0] rxQ[$];

  int expDone = 0;
  int expFerr = 0;
  int expPerr = 0;
  logic [NB_DATA-1:0] expData = '0;

  uart_rx #(
    .NB_DATA      (NB_DATA),
    .BAUD_DIVISOR (BAUD_DIVISOR)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rx            (i_rx),
    .o_data_rx       (o_data_rx),
    .o_rx_done       (o_rx_done),
    .o_framing_error (o_framing_error),
    .o_parity_error  (o_parity_error)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cycle <= cycle + 1;

  // Pulse monitor samples on the falling edge, away from register updates.
  always @(negedge i_clock) begin
    if (o_rx_done) begin
      doneCount++;
      rxQ.push_back(o_data_rx);
      lastLatency = cycle - startCycle;
      if (prevDone) doubleDone++;
    end
    if (o_framing_error) ferrCount++;
    if (o_parity_error) perrCount++;
    prevDone = o_rx_done;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, ".done"}, doneCount, expDone);
    checkOutput({tag, ".ferr"}, ferrCount, expFerr);
    checkOutput({tag, ".perr"}, perrCount, expPerr);
    checkOutput({tag, ".data"}, 32'(o_data_rx), 32'(expData));
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic driveBit(input logic b);
    i_rx = b;
    repeat (BIT_CLOCKS) @(posedge i_clock);
    #1;
  endtask

  // Sends one frame and updates the outcome model.
  task automatic applyStimulus(input logic [NB_DATA-1:0] d, input logic parBit, input logic stopBit);
    startCycle  = cycle;
    lastLatency = 0;
    driveBit(1'b0);
    for (int i = 0; i < NB_DATA; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(parBit);
`endif
    driveBit(stopBit);
    i_rx = 1'b1;
    if (!stopBit) expFerr++;
    else if (PARITY_EN && (((^d) ^ parBit) == 1'b1)) expPerr++;
    else begin
      expDone++;
      expData = d;
    end
  endtask

  initial begin
    logic [NB_DATA-1:0] d;
    logic stopBit;
    logic parBit;
    int prevExp;

    repeat (5) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("reset.data", 32'(o_data_rx), 32'h0);
    checkOutput("reset.done", 32'(o_rx_done), 32'h0);
    checkOutput("reset.ferr", 32'(o_framing_error), 32'h0);
    checkOutput("reset.perr", 32'(o_parity_error), 32'h0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    idle(40);

    d = 8'hA5;
    applyStimulus(d, ^d, 1'b1);
    idle(40);
    checkFrame("a5");
    checkOutput("a5.latency", 32'(lastLatency >= 300 && lastLatency <= 308), 32'h1);

    d = 8'h3C;
    applyStimulus(d, ^d, 1'b0);
    idle(64);
    checkFrame("3c_ferr");

    i_rx = 1'b0;
    repeat (4) @(posedge i_clock);
    #1;
    idle(100);
    checkFrame("glitch");

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b1);
    idle(40);
    checkFrame("par_good");
    applyStimulus(8'h07, 1'b0, 1'b1);
    idle(40);
    checkFrame("par_bad");
`endif

    // Abort a 0xFF frame with reset during data bit 4.
    startCycle = cycle;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    i_rx = 1'b1;
    repeat (10) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    expData = '0;
    checkOutput("midreset.data", 32'(o_data_rx), 32'(expData));
    checkOutput("midreset.done", 32'(o_rx_done), 32'h0);
    i_reset = 1'b0;
    repeat (BIT_CLOCKS - 13) @(posedge i_clock);
    #1;
    for (int i = 0; i < 4 + int'(PARITY_EN); i++) driveBit(1'b1);
    idle(40);
    checkFrame("aborted");
    d = 8'h11;
    applyStimulus(d, ^d, 1'b1);
    idle(40);
    checkFrame("after_reset");
    checkOutput("after_reset.latency", 32'(lastLatency >= 300 && lastLatency <= 308), 32'h1);

    rxQ.delete();
    for (int i = 0; i < 4; i++) begin
      d = 8'hFF;
      applyStimulus(d, ^d, 1'b1);
    end
    idle(40);
    checkFrame("halt");
    checkOutput("halt.count", 32'(rxQ.size()), 32'd4);
    for (int i = 0; i < rxQ.size(); i++) checkOutput("halt.word", 32'(rxQ[i]), 32'hFF);

    for (int k = 0; k < 20; k++) begin
      d       = NB_DATA'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 9) != 0);
      parBit  = (^d) ^ ($urandom_range(0, 4) == 0);
      prevExp = expDone;
      applyStimulus(d, parBit, stopBit);
      idle($urandom_range(40, 80));
      checkFrame("rand");
      if (expDone != prevExp)
        checkOutput("rand.latency", 32'(lastLatency >= 300 && lastLatency <= 308), 32'h1);
    end

    checkOutput("no_double_done", 32'(doubleDone), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of i_clock.
REQ-002 Parameter NB_DATA, default 8, SHALL set the number of data bits per frame.
REQ-003 Parameter BAUD_DIVISOR, default 163, SHALL set the number of i_clock cycles per oversampling tick, with 16 ticks per bit.
REQ-004 i_clock  input  1  SHALL be the system clock.
REQ-005 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 i_rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-007 o_data_rx  output  NB_DATA  SHALL carry the last correctly received word, held stable until the next good frame.
REQ-008 o_rx_done  output  1  SHALL be a one-cycle pulse marking a new valid o_data_rx; it feeds the debug unit's i_rx_done.
REQ-009 o_framing_error  output  1  SHALL be a one-cycle pulse when the stop bit is sampled low.
REQ-010 o_parity_error  output  1  SHALL be a one-cycle pulse on parity mismatch; it SHALL stay constant 0 when parity is compiled out.

Function
REQ-011 i_rx SHALL pass through a two-flop synchronizer; every sample below uses the synchronized value.
REQ-012 Tick generator: the counter SHALL count 0..BAUD_DIVISOR-1 free-running and wrap to 0. A tick SHALL be asserted for one cycle when the count equals BAUD_DIVISOR-1.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY and STOP. The tick counter s SHALL be 4 bits; the bit counter n SHALL be clog2(NB_DATA) bits.
REQ-014 IDLE: on a tick with the line at 0 -> START, s=0.
REQ-015 START: on a tick with s==7 -> if the line is 0: go to DATA, s=0, n=0; otherwise go to IDLE (glitch reject). Any other tick SHALL increment s.
REQ-016 DATA: on a tick with s==15 -> shift the line into the MSB of the shift register (LSB first on the wire), s=0, n++. When n==NB_DATA-1 the next state SHALL be PARITY if it is enabled, otherwise STOP.
REQ-017 PARITY: on a tick with s==15 -> latch the parity bit, s=0 -> STOP.
REQ-018 STOP: on a tick with s==15 -> return to IDLE. Then exactly one of three outcomes SHALL occur:
  - line 1 and parity OK: o_data_rx is loaded and o_rx_done pulses in the same cycle;
  - line 0: o_framing_error pulses, and o_data_rx and o_rx_done are untouched;
  - line 1 and parity bad: o_parity_error pulses, and o_data_rx and o_rx_done are untouched.
REQ-019 Framing error has priority: if framing and parity errors occur together, only o_framing_error SHALL pulse.
REQ-020 Latency: o_rx_done SHALL rise one i_clock cycle after the tick that samples mid-stop-bit.
REQ-021 A line held low after a framing error SHALL be treated as a new start bit once IDLE sees it on the next tick.
REQ-022 o_rx_done SHALL never assert on two consecutive cycles.

Reset
REQ-023 While i_reset=1, the module SHALL force:
  - FSM = IDLE;
  - s, n, shift register and tick counter = 0;
  - both synchronizer flops = 1;
  - o_data_rx = 0;
  - all pulse outputs = 0.
REQ-024 A reset asserted mid-frame SHALL abandon the frame with no pulse output. Reception SHALL restart only on a falling edge seen after reset is released.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL exist and one even-parity bit SHALL be expected between the data and stop bits; XOR of data and parity bit must equal 0.
REQ-026 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable and removed, frames SHALL be 1+NB_DATA+1 bits, and o_parity_error SHALL be tied to 0.

Verification (BAUD_DIVISOR=2, so one bit = 32 clocks)
REQ-027 Parity off, send 0xA5 with a good stop bit -> o_data_rx=0xA5; one o_rx_done pulse about 304 clocks after the start edge (±4); no error pulses.
REQ-028 Send 0x3C with the stop bit low -> one o_framing_error pulse; o_data_rx keeps its previous value; no o_rx_done.
REQ-029 Line low for 4 clocks only (glitch), then idle -> FSM back to IDLE; no output pulses.
REQ-030 Parity on, 0x07 with parity bit 1 -> o_rx_done and o_data_rx=0x07. Then 0x07 with parity bit 0 -> o_parity_error pulse, data unchanged.
REQ-031 Assert i_reset during data bit 4 of 0xFF, release, then send 0x11 -> no pulse for the aborted frame; o_data_rx=0x11 with one o_rx_done.
REQ-032 Send four bytes back-to-back (0xFF 0xFF 0xFF 0xFF, the debug unit's HALT pattern) -> exactly four o_rx_done pulses, each carrying 0xFF.
